dct_quant_zigzag: RTL
=====================

Name: dct_quant_zigzag

Overview:
- Consumes the 2D DCT output: one 8-coefficient row per beat, 8 beats per 8x8 block.
- Buffers each block in ping-pong memory, quantizes each coefficient by multiplying with a programmable reciprocal table, and emits the block serially in JPEG zigzag order, one 12-bit coefficient per beat.
- Feeds the downstream run-length/entropy coder over a valid/ready handshake.

Parameters:
- IN_WIDTH, 18: signed coefficient width from the DCT.
- OUT_WIDTH, 12: signed quantized coefficient width.
- RECIP_WIDTH, 16: unsigned reciprocal width (Q0.16 fraction, value = 65536/Q).
- RECIP_RESET, 4096: reset value of every table entry (uniform Q=16).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  row beat valid.
- in_ready  out  1  block can accept a row beat.
- in_c0..in_c7  in  IN_WIDTH each  signed row; beat r, lane c = raster coefficient 8r+c.
- qt_we  in  1  reciprocal table write enable.
- qt_addr  in  6  table raster index.
- qt_data  in  RECIP_WIDTH  reciprocal value.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  consumer accepts.
- out_coef  out  OUT_WIDTH  quantized signed coefficient.
- out_pos  out  6  zigzag position 0..63.
- out_last  out  1  high when out_pos==63.

Behaviour:
- Reset (async): full[1:0]=0, wr_bank=0, wr_row=0, rd_bank=0, rd_pos=0, out_valid=0, out_coef=0, out_pos=0, out_last=0, all 64 table entries=RECIP_RESET. Memory contents are not reset. Reset mid-block discards all buffered data.
- in_ready = !full[wr_bank], driven from registers only; no combinational path from out_ready.
- Write side:
  - A beat is accepted when in_valid&&in_ready.
  - It is stored at mem[wr_bank][wr_row][0..7], and wr_row increments.
  - On the beat with wr_row==7: wr_row wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Read side: the output register loads when (!out_valid || out_ready) && full[rd_bank].
  - raster = ZZ[rd_pos]; c = mem[rd_bank][raster>>3][raster&7]; r = RECIP[raster].
  - Product p = c * r, signed 34-bit (r zero-extended).
  - q = (p + 32768) >>> 16 (round half toward +inf).
  - q is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and loaded into out_coef; out_pos = rd_pos; out_last = (rd_pos==63); rd_pos increments.
  - When the loaded coefficient is position 63: full[rd_bank] clears, rd_bank toggles, and rd_pos wraps to 0.
  - If the output register does not load and out_ready is high, out_valid clears.
- Latency: the final row beat is accepted at edge N; position 0 is valid after edge N+1.
- Throughput: 1 coefficient/cycle under out_ready=1, giving 64 cycles/block. The input side stalls when both banks are full.
- Stall: while out_valid && !out_ready, out_coef, out_pos and out_last hold stable.
- Bank freed by loading position 63 at edge M: in_ready rises after edge M, and the write side may accept the next beat at M+1.
- Simultaneous events:
  - The last write beat into bank A and the last read from bank B on the same edge are both honoured.
  - A full flag set and cleared on the same edge cannot target the same bank.
- Table write: a qt_we write takes effect at the edge; a coefficient loaded on the same edge uses the old value. Writes while a block is draining are legal; the affected coefficients use whichever value is current when they load.
- No X on outputs after reset.

Decomposition:
- Package dct_pkg holds:
  - ZZ_ORDER, the 64-entry constant raster index per zigzag position (0,1,8,16,9,2,3,10,17,24,…,63).
  - Width localparams and RECIP_RESET.
  - A saturate function.
- Sub-module quant_mul: combinational multiply-round-saturate. Inputs are the coefficient and reciprocal; output is q.

Test Plan:
- Reset table; all 64 coefficients = 160 -> every out_coef=10. Coefficient 24 -> 2; coefficient -24 -> -1. out_last high only on the 64th beat.
- Table all 65535; block with raster value v at index v (0..63) -> output sequence 0,1,8,16,9,2,3,10,17,24,…,63. out_pos counts 0..63.
- Table all 65535; coefficient 131071 -> 2047; coefficient -131072 -> -2048 (saturation).
- Three blocks offered back-to-back with out_ready=1:
  - in_ready drops after 16 beats.
  - in_ready returns one cycle after block 0 loads position 63.
  - 192 coefficients are delivered with no gap between blocks.
- out_ready toggled randomly, plus a 5-cycle low hold at position 20 -> out_coef/out_pos stable throughout; no loss or duplication.
- rst_n asserted after block row 4 and at output position 30 -> outputs return to 0 immediately and in_ready=1. A fresh block then passes correctly.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared widths, the JPEG zigzag scan table and the output saturation helper
// for the DCT quantizer / zigzag serializer.
package dct_pkg;

    localparam int IN_WIDTH    = 18;
    localparam int OUT_WIDTH   = 12;
    localparam int RECIP_WIDTH = 16;
    localparam int PROD_W      = IN_WIDTH + RECIP_WIDTH + 1;

    localparam logic [RECIP_WIDTH-1:0] RECIP_RESET = 16'd4096;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        PROD_W'((32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        PROD_W'(-(32'sd1 <<< (OUT_WIDTH - 1)));

    // Raster index of the coefficient emitted at each zigzag position.
    localparam logic [5:0] ZZ_ORDER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PROD_W-1:0] v);
        logic signed [OUT_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dct_quant_zigzag_quant_mul.sv
// Combinational quantizer: coefficient times Q0.16 reciprocal, round half
// toward +inf, then clamp to the signed output range.
module quant_mul
    import dct_pkg::*;
(
    input  logic signed [IN_WIDTH-1:0]    coef_i,
    input  logic        [RECIP_WIDTH-1:0] recip_i,
    output logic signed [OUT_WIDTH-1:0]   q_o
);

    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(32'sd1 <<< (RECIP_WIDTH - 1));

    logic signed [PROD_W-1:0] coef_ext_s;
    logic signed [PROD_W-1:0] recip_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] sum_s;
    logic signed [PROD_W-1:0] shr_s;

    // Reciprocal is unsigned, so it is zero-extended before the signed multiply.
    assign coef_ext_s  = PROD_W'(coef_i);
    assign recip_ext_s = $signed(PROD_W'(recip_i));
    assign prod_s      = coef_ext_s * recip_ext_s;
    assign sum_s       = prod_s + ROUND_BIAS;
    assign shr_s       = sum_s >>> RECIP_WIDTH;
    assign q_o         = saturate(shr_s);

endmodule

// File: rtl/dct_quant_zigzag.sv
// Ping-pong 8x8 block buffer: rows in, quantized coefficients out in zigzag
// order over a valid/ready handshake with a fully registered output stage.
module dct_quant_zigzag
    import dct_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [IN_WIDTH-1:0]    in_c0,
    input  logic signed [IN_WIDTH-1:0]    in_c1,
    input  logic signed [IN_WIDTH-1:0]    in_c2,
    input  logic signed [IN_WIDTH-1:0]    in_c3,
    input  logic signed [IN_WIDTH-1:0]    in_c4,
    input  logic signed [IN_WIDTH-1:0]    in_c5,
    input  logic signed [IN_WIDTH-1:0]    in_c6,
    input  logic signed [IN_WIDTH-1:0]    in_c7,
    input  logic                          qt_we,
    input  logic        [5:0]             qt_addr,
    input  logic        [RECIP_WIDTH-1:0] qt_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_coef,
    output logic        [5:0]             out_pos,
    output logic                          out_last
);

    logic signed [IN_WIDTH-1:0]    mem_q [2][64];
    logic        [RECIP_WIDTH-1:0] recip_q [64];

    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [5:0] rd_pos_q,  rd_pos_d;
    logic       out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0] out_coef_q, out_coef_d;
    logic [5:0] out_pos_q, out_pos_d;
    logic       out_last_q, out_last_d;

    logic signed [IN_WIDTH-1:0]    row_s [8];
    logic                          wr_fire_s;
    logic                          ld_s;
    logic [5:0]                    raster_s;
    logic signed [IN_WIDTH-1:0]    coef_s;
    logic [RECIP_WIDTH-1:0]        recip_s;
    logic signed [OUT_WIDTH-1:0]   q_s;

    assign row_s     = '{in_c0, in_c1, in_c2, in_c3, in_c4, in_c5, in_c6, in_c7};
    assign in_ready  = ~full_q[wr_bank_q];
    assign wr_fire_s = in_valid & ~full_q[wr_bank_q];
    assign ld_s      = (~out_valid_q | out_ready) & full_q[rd_bank_q];
    assign raster_s  = ZZ_ORDER[rd_pos_q];
    assign coef_s    = mem_q[rd_bank_q][raster_s];
    assign recip_s   = recip_q[raster_s];

    quant_mul u_quant_mul (
        .coef_i  (coef_s),
        .recip_i (recip_s),
        .q_o     (q_s)
    );

    // Next-state for bank bookkeeping and the output register.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_row_d    = wr_row_q;
        rd_bank_d   = rd_bank_q;
        rd_pos_d    = rd_pos_q;
        out_valid_d = out_valid_q;
        out_coef_d  = out_coef_q;
        out_pos_d   = out_pos_q;
        out_last_d  = out_last_q;

        if (wr_fire_s) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_bank_d = wr_bank_q;
            end
        end else begin
            wr_row_d = wr_row_q;
        end

        // A set and a clear in the same cycle always hit different banks.
        if (ld_s) begin
            out_valid_d = 1'b1;
            out_coef_d  = q_s;
            out_pos_d   = rd_pos_q;
            out_last_d  = (rd_pos_q == 6'd63);
            rd_pos_d    = rd_pos_q + 6'd1;
            if (rd_pos_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            wr_row_q    <= 3'd0;
            rd_bank_q   <= 1'b0;
            rd_pos_q    <= 6'd0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_pos_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_row_q    <= wr_row_d;
            rd_bank_q   <= rd_bank_d;
            rd_pos_q    <= rd_pos_d;
            out_valid_q <= out_valid_d;
            out_coef_q  <= out_coef_d;
            out_pos_q   <= out_pos_d;
            out_last_q  <= out_last_d;
        end
    end

    // Reciprocal table; a coefficient loaded on the write edge sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                recip_q[i] <= RECIP_RESET;
            end
        end else if (qt_we) begin
            recip_q[qt_addr] <= qt_data;
        end
    end

    // Block memory, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            for (int c = 0; c < 8; c++) begin
                mem_q[wr_bank_q][{wr_row_q, 3'(c)}] <= row_s[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_coef  = out_coef_q;
    assign out_pos   = out_pos_q;
    assign out_last  = out_last_q;

endmodule
